// File: rtl/complex_matrix_result_drain.sv
// Result drain: captures a full 2*SIZE-word complex result vector in one handshake and
// streams it out one 64-bit word per beat. Optional macro CMPLX_DRAIN_BACK2BACK_EN removes the inter-vector bubble.
module complex_matrix_result_drain #(
    parameter int SIZE  = 16,
    parameter int IDX_W = $clog2(2*SIZE)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [SIZE*2-1:0][63:0]  result_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     flush_i,
    output logic [63:0]              out_data_o,
    output logic [IDX_W-1:0]         out_idx_o,
    output logic                     out_last_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     busy_o
);

    localparam int               WORDS    = 2 * SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [WORDS-1:0][63:0]   buffer_q;
    logic                     load;
    logic                     beat;
    logic                     accept;

    // Outputs are decoded from registers only; out_ready_i never reaches them.
    assign out_valid_o = (state_q == DRAIN);
    assign out_last_o  = (state_q == DRAIN) && (idx_q == LAST_IDX);
    assign out_data_o  = buffer_q[idx_q];
    assign out_idx_o   = idx_q;
    assign busy_o      = (state_q == DRAIN);

`ifdef CMPLX_DRAIN_BACK2BACK_EN
    assign in_ready_o = ~flush_i & ((state_q == IDLE) | (out_last_o & out_ready_i));
`else
    assign in_ready_o = ~flush_i & (state_q == IDLE);
`endif

    assign beat   = out_valid_o & out_ready_i;
    assign accept = in_valid_i & in_ready_o;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (accept) begin
            // Covers both an IDLE accept and a back-to-back reload on the last beat.
            state_d = DRAIN;
            idx_d   = '0;
            load    = 1'b1;
        end else if (beat) begin
            if (idx_q == LAST_IDX) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: the buffer is reset because out_data_o must read zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buffer_q <= '0;
        end else if (load) begin
            buffer_q <= result_i;
        end
    end

endmodule

// File: tb/tb_complex_matrix_result_drain.sv
// Directed self-checking bench for complex_matrix_result_drain with SIZE=4 (8 words per vector).
module tb_complex_matrix_result_drain;

    localparam int SIZE  = 4;
    localparam int WORDS = 2 * SIZE;
    localparam int IDX_W = 3;

    typedef logic [WORDS-1:0][63:0] vec_t;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    vec_t               result_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic               flush_i;
    logic [63:0]        out_data_o;
    logic [IDX_W-1:0]   out_idx_o;
    logic               out_last_o;
    logic               out_valid_o;
    logic               out_ready_i;
    logic               busy_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    complex_matrix_result_drain #(.SIZE(SIZE), .IDX_W(IDX_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .result_i    (result_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .flush_i     (flush_i),
        .out_data_o  (out_data_o),
        .out_idx_o   (out_idx_o),
        .out_last_o  (out_last_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk_vec(input logic [63:0] base);
        vec_t v;
        for (int k = 0; k < WORDS; k++) v[k] = base + 64'(k);
        return v;
    endfunction

    // Expected {valid, idx, last, data}; last is only ever set on a valid final word.
    function automatic logic [IDX_W+65:0] exp_beat(input logic v, input int idx, input logic [63:0] d);
        return {v, IDX_W'(idx), v && (idx == WORDS - 1), d};
    endfunction

    wire [IDX_W+65:0] obs = {out_valid_o, out_idx_o, out_last_o, out_data_o};

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1; result_i = '0;
        #3;
        total_cnt++;
        if (obs !== exp_beat(0, 0, 64'h0)) $display("FAIL reset_outputs got=%h want=%h", obs, exp_beat(0, 0, 64'h0));
        else pass_cnt++;
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy_o);
        else pass_cnt++;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        #1;
        total_cnt++;
        if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready_o);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_basic_drain();
        result_i = mk_vec(64'h1000); in_valid_i = 1'b1;
        #1;
        total_cnt++;
        if (in_ready_o !== 1'b1) $display("FAIL basic_in_ready got=%b want=1", in_ready_o);
        else pass_cnt++;
        tick();
        in_valid_i = 1'b0;
        for (int k = 0; k < WORDS; k++) begin
            total_cnt++;
            if (obs !== exp_beat(1, k, 64'h1000 + 64'(k)))
                $display("FAIL basic_beat%0d got=%h want=%h", k, obs, exp_beat(1, k, 64'h1000 + 64'(k)));
            else pass_cnt++;
            total_cnt++;
            if (busy_o !== 1'b1) $display("FAIL basic_busy%0d got=%b want=1", k, busy_o);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (obs !== exp_beat(0, 0, 64'h1000)) $display("FAIL basic_idle got=%h want=%h", obs, exp_beat(0, 0, 64'h1000));
        else pass_cnt++;
        total_cnt++;
        if ({busy_o, in_ready_o} !== 2'b01) $display("FAIL basic_end_busy_ready got=%b want=01", {busy_o, in_ready_o});
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic exp_rdy;
        int   k = 0;
        result_i = mk_vec(64'h2000); in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        for (int c = 0; c < 40 && k < WORDS; c++) begin
            out_ready_i = pat[c % 4];
            #1;
            total_cnt++;
            if (obs !== exp_beat(1, k, 64'h2000 + 64'(k)))
                $display("FAIL bp_cycle%0d got=%h want=%h", c, obs, exp_beat(1, k, 64'h2000 + 64'(k)));
            else pass_cnt++;
`ifdef CMPLX_DRAIN_BACK2BACK_EN
            exp_rdy = (k == WORDS - 1) && out_ready_i;
`else
            exp_rdy = 1'b0;
`endif
            total_cnt++;
            if (in_ready_o !== exp_rdy) $display("FAIL bp_in_ready%0d got=%b want=%b", c, in_ready_o, exp_rdy);
            else pass_cnt++;
            if (out_ready_i) k++;
            tick();
        end
        total_cnt++;
        if (k != WORDS) $display("FAIL bp_timeout beats=%0d want=%0d", k, WORDS);
        else pass_cnt++;
        out_ready_i = 1'b1;
        total_cnt++;
        if (obs !== exp_beat(0, 0, 64'h2000)) $display("FAIL bp_idle got=%h want=%h", obs, exp_beat(0, 0, 64'h2000));
        else pass_cnt++;
    endtask

    task automatic test_hold_last();
        result_i = mk_vec(64'h3000); in_valid_i = 1'b1; out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        repeat (WORDS - 1) tick();
        out_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            total_cnt++;
            if (obs !== exp_beat(1, 7, 64'h3007)) $display("FAIL hold_last%0d got=%h want=%h", c, obs, exp_beat(1, 7, 64'h3007));
            else pass_cnt++;
            total_cnt++;
            if (in_ready_o !== 1'b0) $display("FAIL hold_in_ready%0d got=%b want=0", c, in_ready_o);
            else pass_cnt++;
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        total_cnt++;
        if (out_valid_o !== 1'b0) $display("FAIL hold_release got=%b want=0", out_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        result_i = mk_vec(64'h4000); in_valid_i = 1'b1; out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if (obs !== exp_beat(1, 3, 64'h4003)) $display("FAIL flush_at3 got=%h want=%h", obs, exp_beat(1, 3, 64'h4003));
        else pass_cnt++;
        flush_i = 1'b1; in_valid_i = 1'b1; result_i = mk_vec(64'h5000);
        #1;
        total_cnt++;
        if (in_ready_o !== 1'b0) $display("FAIL flush_in_ready got=%b want=0", in_ready_o);
        else pass_cnt++;
        tick();
        flush_i = 1'b0;
        #1;
        // Buffer still holds the flushed vector: proves nothing was accepted during the flush.
        total_cnt++;
        if (obs !== exp_beat(0, 0, 64'h4000)) $display("FAIL flush_idle got=%h want=%h", obs, exp_beat(0, 0, 64'h4000));
        else pass_cnt++;
        total_cnt++;
        if ({busy_o, in_ready_o} !== 2'b01) $display("FAIL flush_busy_ready got=%b want=01", {busy_o, in_ready_o});
        else pass_cnt++;
        tick();
        in_valid_i = 1'b0;
        for (int k = 0; k < WORDS; k++) begin
            total_cnt++;
            if (obs !== exp_beat(1, k, 64'h5000 + 64'(k)))
                $display("FAIL flush_next%0d got=%h want=%h", k, obs, exp_beat(1, k, 64'h5000 + 64'(k)));
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        result_i = mk_vec(64'h6000); in_valid_i = 1'b1; out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        repeat (5) tick();
        total_cnt++;
        if (obs !== exp_beat(1, 5, 64'h6005)) $display("FAIL arst_at5 got=%h want=%h", obs, exp_beat(1, 5, 64'h6005));
        else pass_cnt++;
        #2 rst_ni = 1'b0;
        #1;
        total_cnt++;
        if (obs !== exp_beat(0, 0, 64'h0)) $display("FAIL arst_outputs got=%h want=%h", obs, exp_beat(0, 0, 64'h0));
        else pass_cnt++;
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL arst_busy got=%b want=0", busy_o);
        else pass_cnt++;
        @(negedge clk_i) rst_ni = 1'b1;
        #1;
        total_cnt++;
        if (in_ready_o !== 1'b1) $display("FAIL arst_in_ready got=%b want=1", in_ready_o);
        else pass_cnt++;
        result_i = mk_vec(64'h7000); in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        for (int k = 0; k < WORDS; k++) begin
            total_cnt++;
            if (obs !== exp_beat(1, k, 64'h7000 + 64'(k)))
                $display("FAIL arst_fresh%0d got=%h want=%h", k, obs, exp_beat(1, k, 64'h7000 + 64'(k)));
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int          sent = 1;
        int          n_cyc;
        logic        v;
        int          i;
        logic [63:0] d;
`ifdef CMPLX_DRAIN_BACK2BACK_EN
        n_cyc = 2 * WORDS + 1;
`else
        n_cyc = 2 * WORDS + 2;
`endif
        result_i = mk_vec(64'hA000); in_valid_i = 1'b1; out_ready_i = 1'b1;
        tick();
        for (int c = 0; c < n_cyc; c++) begin
            if (sent == 1) result_i = mk_vec(64'hB000);
            if (sent == 2) in_valid_i = 1'b0;
            #1;
`ifdef CMPLX_DRAIN_BACK2BACK_EN
            if (c < 2 * WORDS) begin
                v = 1'b1; i = c % WORDS; d = (c < WORDS ? 64'hA000 : 64'hB000) + 64'(i);
            end else begin
                v = 1'b0; i = 0; d = 64'hB000;
            end
`else
            if (c < WORDS) begin
                v = 1'b1; i = c; d = 64'hA000 + 64'(i);
            end else if (c == WORDS) begin
                v = 1'b0; i = 0; d = 64'hA000;
            end else if (c <= 2 * WORDS) begin
                v = 1'b1; i = c - WORDS - 1; d = 64'hB000 + 64'(i);
            end else begin
                v = 1'b0; i = 0; d = 64'hB000;
            end
`endif
            total_cnt++;
            if (obs !== exp_beat(v, i, d)) $display("FAIL b2b_cycle%0d got=%h want=%h", c, obs, exp_beat(v, i, d));
            else pass_cnt++;
            if (in_valid_i && in_ready_o) sent++;
            tick();
        end
        total_cnt++;
        if (sent != 2) $display("FAIL b2b_accepts got=%0d want=2", sent);
        else pass_cnt++;
        in_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_hold_last();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/complex_matrix_result_drain.md
# complex_matrix_result_drain

Downstream stage of the complex matrix adder. It captures one full result vector of 2*SIZE 64-bit words in a single handshake and streams it out one word per beat over a narrow valid/ready interface, with element index and last-beat markers. The narrow output feeds the writeback/store path, which cannot accept the full-width vector.

## Interface
Parameters:
- SIZE, default 16: number of complex results per vector; the vector holds 2*SIZE words; SIZE >= 1.
- IDX_W, default $clog2(2*SIZE) (minimum 1): width of the beat index.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- result_i  in  [SIZE*2-1:0][63:0]  result vector; word 2i is the real part of element i, word 2i+1 is the imaginary part.
- in_valid_i  in  1  result_i is valid.
- in_ready_o  out  1  block accepts a vector this cycle.
- flush_i  in  1  abort the current drain and discard the buffered vector.
- out_data_o  out  64  current word.
- out_idx_o  out  IDX_W  word index of out_data_o, 0..2*SIZE-1.
- out_last_o  out  1  the current beat is word 2*SIZE-1.
- out_valid_o  out  1  out_data_o is valid.
- out_ready_i  in  1  consumer accepts the beat.
- busy_o  out  1  a vector is held or draining.

## Operation
- States: IDLE and DRAIN. Internal registers: buffer [2*SIZE][64] and index counter idx.
- Accept: in_valid_i & in_ready_o at an edge. This captures result_i into the buffer, sets idx=0 and moves to DRAIN.
- in_ready_o = (state==IDLE) & ~flush_i. The back-to-back term is defined under Configuration.
- In DRAIN:
  - out_valid_o=1.
  - out_data_o=buffer[idx].
  - out_idx_o=idx.
  - out_last_o = (idx==2*SIZE-1).
- In IDLE: out_valid_o=0 and out_last_o=0. out_data_o and out_idx_o are don't-care for the consumer, but they still reflect buffer[idx] and idx.
- Beat: out_valid_o & out_ready_i at an edge.
  - A non-last beat increments idx.
  - The last beat returns the block to IDLE with idx=0, unless a back-to-back reload occurs.
- out_data_o, out_idx_o and out_last_o are held stable while out_valid_o=1 and out_ready_i=0.
- The buffer is not modified during DRAIN, except by a back-to-back reload.
- busy_o = (state==DRAIN).
- flush_i:
  - In any state, a flush makes the next state IDLE with idx=0.
  - Flush takes priority over beat completion and over accept.
  - A beat handshaking in the same cycle as flush_i counts as transferred on the consumer side; the drain still ends.
  - Buffer contents are left unchanged.
- Reset (rst_ni low, asynchronous, including mid-drain):
  - state=IDLE, idx=0, buffer=0.
  - out_valid_o=0, out_last_o=0, busy_o=0, out_data_o=0, out_idx_o=0.
  - in_ready_o=1 once reset is released, provided flush_i=0.
- idx never exceeds 2*SIZE-1. There is no wrap path other than a return to 0 on the last beat, a flush or a reset.

## Timing
- Latency: a vector accepted at edge N presents word 0 with out_valid_o=1 in cycle N+1.
- With out_ready_i held at 1, word k is presented in cycle N+1+k. The last word is presented in cycle N+2*SIZE.
- Without back-to-back: the earliest next accept is edge N+2*SIZE+1, because in_ready_o is high in cycle N+2*SIZE+1. One bubble cycle separates vectors.
- in_ready_o depends combinationally on state and flush_i, plus out_ready_i and idx when back-to-back is enabled. The block never makes in_ready_o depend on in_valid_i.
- out_valid_o, out_data_o, out_idx_o and out_last_o come from registers only (state, idx, buffer). There is no combinational path from out_ready_i to these outputs.

## Configuration
- Macro: CMPLX_DRAIN_BACK2BACK_EN.
- Defined:
  - in_ready_o = ~flush_i & ((state==IDLE) | (state==DRAIN & out_last_o & out_ready_i)).
  - An accept coinciding with the last beat reloads the buffer, sets idx=0 and stays in DRAIN.
  - Word 0 of the new vector is presented in the next cycle, so there are no bubbles between vectors.
- Undefined: in_ready_o is high only in IDLE, and vectors are separated by one bubble cycle.

## Test plan
- Basic drain:
  - Stimulus: reset, SIZE=4; accept a vector with word k = 64'h1000+k; out_ready_i=1.
  - Response: 8 consecutive beats, idx 0..7, data 0x1000..0x1007, out_last_o only on idx 7; busy_o deasserts after the 8th beat.
- Backpressure:
  - Stimulus: out_ready_i toggling 1,0,0,1 during the drain.
  - Response: data and idx held stable while stalled; no word lost or duplicated; in_ready_o=0 throughout.
- Back-to-back:
  - Stimulus: in_valid_i held high with two vectors (0xA.., 0xB..).
  - Response with CMPLX_DRAIN_BACK2BACK_EN: 16 beats in 16 cycles.
  - Response without it: exactly one cycle with out_valid_o=0 between the two vectors.
- Flush mid-drain:
  - Stimulus: assert flush_i at idx=3 together with a beat; in_valid_i=1 in the same cycle.
  - Response: next cycle IDLE, out_valid_o=0, idx=0, no accept in the flush cycle; the following vector then drains from word 0.
- Async reset mid-drain:
  - Stimulus: drop rst_ni between edges at idx=5.
  - Response: out_valid_o, busy_o and out_idx_o go to 0 immediately; after release, in_ready_o=1 and a fresh vector drains from idx 0.
- Hold on stall at last:
  - Stimulus: stall on idx 7 for 5 cycles.
  - Response: out_last_o stays 1 and in_ready_o stays 0 until out_ready_i rises.
